// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared pipeline defines for the instruction-fetch stage:
//               FSM state encoding, datapath width, reset/NOP defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch FSM states, 2-bit explicit encoding
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // ready to issue a fetch
        S_WAIT = 2'd1,  // one request outstanding
        S_HOLD = 2'd2   // response parked while decode is stalled
    } fetch_state_t;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_WORD = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC       = 32'd4;
    // Clears the byte-offset bits so every fetch address is word aligned
    localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory request/response bus between the fetch
//               stage (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if_id_reg
// Description : IF/ID pipeline register. Flush beats hold, hold beats load,
//               and an idle cycle inserts a bubble (NOP, not valid).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_flush,
    input  wire logic            i_hold,
    input  wire logic            i_load,
    input  wire logic [XLEN-1:0] i_instr,
    input  wire logic [XLEN-1:0] i_pc_plus4,
    output logic      [XLEN-1:0] o_instruction,
    output logic      [XLEN-1:0] o_pc_plus4,
    output logic                 o_id_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    // IF/ID contents: reset, flush, hold, load or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_instr    <= r_instr;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end else begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end
    end

    assign o_instruction = r_instr;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_id_valid    = r_valid;

endmodule : fetch_stage_if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Pipeline stage one. Holds the PC, issues one word fetch at a
//               time to instruction memory, parks a response in a hold buffer
//               while decode stalls, and discards fetches made stale by a
//               branch/jump redirect from decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            stall,
    input  wire logic            branch_taken,
    input  wire logic [XLEN-1:0] branch_target,
    input  wire logic            jump,
    input  wire logic [XLEN-1:0] jump_target,
    fetch_stage_if.master        imem,
    output logic      [XLEN-1:0] instruction,
    output logic      [XLEN-1:0] pc_plus4,
    output logic                 id_valid
);

    fetch_state_t    r_state,      w_state_nxt;
    logic [XLEN-1:0] r_pc,         w_pc_nxt;
    logic [XLEN-1:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic            r_discard,    w_discard_nxt;
    logic [XLEN-1:0] r_hold_instr, w_hold_instr_nxt;
    logic [XLEN-1:0] r_hold_pc4,   w_hold_pc4_nxt;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fetch_pc4;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic [XLEN-1:0] w_load_pc4;

    // Branch outranks jump when both are flagged; byte offset is dropped
    assign w_redirect  = branch_taken | jump;
    assign w_target    = (branch_taken ? branch_target : jump_target) & WORD_MASK;
    assign w_fetch_pc4 = r_fetch_pc + PC_INC;

    // A request is only offered from S_REQ, and never in a redirect cycle
    // because the PC is about to change underneath it
    assign imem.imem_req  = (r_state == S_REQ) & ~w_redirect & ~rst;
    assign imem.imem_addr = r_pc & WORD_MASK;

    // FSM, PC and hold-buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC & WORD_MASK;
            r_fetch_pc   <= '0;
            r_discard    <= 1'b0;
            r_hold_instr <= NOP_WORD;
            r_hold_pc4   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc4   <= w_hold_pc4_nxt;
        end
    end

    // Next-state, PC update and IF/ID load selection
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_discard_nxt    = r_discard;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc4_nxt   = r_hold_pc4;
        w_load           = 1'b0;
        w_load_instr     = imem.imem_rdata;
        w_load_pc4       = w_fetch_pc4;

        case (r_state)
            S_REQ: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else if (imem.imem_ready) begin
                    w_fetch_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + PC_INC;
                    w_state_nxt    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                    if (imem.imem_rvalid) begin
                        // The stale response lands now, so nothing is left
                        // to discard later
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (imem.imem_rvalid) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else if (!stall) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_hold_instr_nxt = imem.imem_rdata;
                        w_hold_pc4_nxt   = w_fetch_pc4;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold_instr;
                    w_load_pc4   = r_hold_pc4;
                    w_state_nxt  = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    fetch_stage_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (w_redirect),
        .i_hold        (stall),
        .i_load        (w_load),
        .i_instr       (w_load_instr),
        .i_pc_plus4    (w_load_pc4),
        .o_instruction (instruction),
        .o_pc_plus4    (pc_plus4),
        .o_id_valid    (id_valid)
    );

endmodule : fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage (pipeline stage one) plus the IF/ID pipeline register, directly upstream of the decode stage. It holds the PC and issues word fetches to instruction memory, allowing one request in flight with variable latency. It presents instruction, pc_plus4 and a valid flag to decode, holds them under a decode stall, and flushes on a branch or jump redirect from decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction value driven when the IF/ID register is empty or flushed.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  decode hazard; IF/ID register must hold
branch_taken  in  1  branch resolved taken in decode
branch_target  in  32  branch destination address
jump  in  1  jump in decode
jump_target  in  32  jump destination, already formed
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  fetched instruction word
instruction  out  32  IF/ID instruction to decode
pc_plus4  out  32  IF/ID address of fetched instruction + 4
id_valid  out  1  IF/ID holds a live instruction

Behaviour:
- Redirect is branch_taken OR jump. Target is branch_target if branch_taken, else jump_target.
- Priority order: rst, then redirect, then stall, then normal flow.
- Reset: pc=RESET_PC, state=S_REQ, id_valid=0, instruction=NOP_WORD, pc_plus4=0, discard=0, hold buffer empty. imem_req=0 during the reset cycle.
- At most one memory request is outstanding. fetch_pc records the address of the in-flight request.
- imem_req = (state==S_REQ) & ~redirect & ~rst. imem_addr = pc.
- S_REQ:
  - On redirect: pc<=target. Stay in S_REQ. No request is issued that cycle.
  - Else, if imem_ready: fetch_pc<=pc, pc<=pc+4, go to S_WAIT.
- S_WAIT (no new request issued):
  - On redirect: pc<=target, discard<=1, stay in S_WAIT.
  - On imem_rvalid with discard=1: drop the data, discard<=0, go to S_REQ.
  - On imem_rvalid with discard=0 and no stall: instruction<=imem_rdata, pc_plus4<=fetch_pc+4, id_valid<=1, go to S_REQ.
  - On imem_rvalid with discard=0 and stall: capture data and fetch_pc+4 in the hold buffer, go to S_HOLD.
  - Redirect in the same cycle as rvalid: the data is dropped, discard stays 0, go to S_REQ with pc=target.
- S_HOLD:
  - On redirect: drop the hold buffer, pc<=target, go to S_REQ.
  - Else, if stall deasserted: load IF/ID from the hold buffer, id_valid<=1, go to S_REQ.
- IF/ID register:
  - Redirect: id_valid<=0 and instruction<=NOP_WORD in the same edge (flush). This overrides stall.
  - stall without redirect: instruction, pc_plus4 and id_valid all hold.
  - No stall, no redirect, no new data: id_valid<=0, instruction<=NOP_WORD (bubble).
- Arithmetic: pc+4 is 32-bit and wraps at 2^32 with no flag. The low two bits of targets are ignored; imem_addr[1:0] is forced to 0.
- rst asserted in any state aborts the in-flight fetch; any later imem_rvalid is ignored until a new request is accepted.
- Throughput: with single-cycle memory (ready=1, rvalid the cycle after acceptance), one instruction every 2 cycles.

Decomposition:
- Shared package (pipeline defines): state encoding S_REQ/S_WAIT/S_HOLD (2 bits), NOP_WORD, RESET_PC default, PC_INC=4.
- One natural sub-module, if_id_reg: the IF/ID register with load, hold and flush controls. The FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset, then ready=1 with rvalid one cycle after each acceptance, rdata=addr^32'hA5A5_0000: imem_addr sequence 0,4,8. IF/ID shows pc_plus4 4,8,12 with id_valid pulsing every 2 cycles.
- Stall for 3 cycles while a response arrives (rdata=32'h1234_5678): IF/ID holds its old value. On release, instruction=32'h1234_5678 with the correct pc_plus4, and no request is issued during S_HOLD.
- Branch_taken (target 32'h40) while in S_WAIT for addr 8: the late rdata is discarded. The next imem_addr is 32'h40, and IF/ID is flushed (id_valid=0, instruction=NOP_WORD).
- Redirect and stall in the same cycle with id_valid=1: the flush wins, id_valid=0 next edge. The jump to 32'h100 gives next imem_addr=32'h100.
- rst asserted in S_WAIT, rvalid arriving 1 cycle after rst drops: the data is ignored. imem_addr=RESET_PC and all outputs equal their reset values.
- PC at 32'hFFFF_FFFC, fetch accepted: pc wraps to 0 and pc_plus4 for that instruction is 0. Hold imem_ready=0 for 5 cycles: imem_req stays 1 with a stable address.
